// File: rtl/miso_share_arbiter.sv
// Round-robin owner sequencer for the shared MISO tristate enables ss1/ss2 with bounded hold and all-off turnaround.
// Optional per-requester grant counters gcnt1/gcnt2 are built only when ARB_GRANT_CNT_EN is defined.
module miso_share_arbiter #(
  parameter int HOLD_MAX    = 16,
  parameter int TURN_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req1,
  input  logic             req2,
  output logic             ss1,
  output logic             ss2,
  output logic [1:0]       owner,
  output logic             busy,
  output logic             timeout
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0] gcnt1,
  output logic [CNT_W-1:0] gcnt2
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT1 = 2'd1;
  localparam logic [1:0] GRANT2 = 2'd2;
  localparam logic [1:0] TURN   = 2'd3;

  localparam int              HOLD_W       = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam bit              HOLD_LIMITED = (HOLD_MAX != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
  localparam logic [3:0]      TURN_LAST    = 4'(TURN_CYCLES - 1);

  if (CNT_W < 1 || TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_badParam
    $error("miso_share_arbiter: illegal parameter value");
  end

  logic [1:0]        r_state;
  logic [HOLD_W-1:0] r_hold;
  logic [3:0]        r_turn;
  logic [1:0]        r_lastOwner;

  logic [1:0] w_pick;
  logic [1:0] w_next;
  logic       w_timeout;
  logic       w_reqOwn;
  logic       w_holdDone;
  logic       w_enter1;
  logic       w_enter2;

  // Ties go to whichever side did not own the line last.
  always_comb begin
    w_pick = IDLE;
    if (req1 && (!req2 || r_lastOwner == 2'd2)) begin
      w_pick = GRANT1;
    end else if (req2) begin
      w_pick = GRANT2;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_timeout  = 1'b0;
    w_reqOwn   = (r_state == GRANT1) ? req1 : req2;
    w_holdDone = HOLD_LIMITED && (r_hold == HOLD_LAST);
    case (r_state)
      IDLE: w_next = w_pick;
      GRANT1, GRANT2: begin
        if (!w_reqOwn) begin
          w_next = TURN;
        end else if (w_holdDone) begin
          w_next    = TURN;
          w_timeout = 1'b1;
        end
      end
      default: begin
        if (r_turn == TURN_LAST) begin
          w_next = w_pick;
        end
      end
    endcase
  end

  assign w_enter1 = (w_next == GRANT1) && (r_state != GRANT1);
  assign w_enter2 = (w_next == GRANT2) && (r_state != GRANT2);

  // Outputs are registered from the next state so the enables never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_turn      <= '0;
      r_lastOwner <= 2'd2;
      ss1         <= 1'b0;
      ss2         <= 1'b0;
      owner       <= 2'd0;
      busy        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      r_state <= w_next;
      ss1     <= (w_next == GRANT1);
      ss2     <= (w_next == GRANT2);
      owner   <= (w_next == GRANT1) ? 2'd1 : ((w_next == GRANT2) ? 2'd2 : 2'd0);
      busy    <= (w_next != IDLE);
      timeout <= w_timeout;

      if ((w_next == r_state) && (r_state == GRANT1 || r_state == GRANT2)) begin
        r_hold <= r_hold + HOLD_W'(1);
      end else begin
        r_hold <= '0;
      end

      if ((w_next == TURN) && (r_state == TURN)) begin
        r_turn <= r_turn + 4'd1;
      end else begin
        r_turn <= '0;
      end

      if (w_enter1) begin
        r_lastOwner <= 2'd1;
      end else if (w_enter2) begin
        r_lastOwner <= 2'd2;
      end
    end
  end

`ifdef ARB_GRANT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt1 <= '0;
      gcnt2 <= '0;
    end else begin
      if (w_enter1 && (gcnt1 != '1)) begin
        gcnt1 <= gcnt1 + CNT_W'(1);
      end
      if (w_enter2 && (gcnt2 != '1)) begin
        gcnt2 <= gcnt2 + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_miso_share_arbiter.sv
// Directed self-checking bench for miso_share_arbiter: one default instance (A) and one with
// HOLD_MAX=0, CNT_W=2 (B); grant-counter checks are built only when ARB_GRANT_CNT_EN is defined.
module tb_miso_share_arbiter;

  // Expected {ss1, ss2, owner[1:0], busy, timeout}
  localparam logic [5:0] EXP_IDLE    = 6'b0_0_00_0_0;
  localparam logic [5:0] EXP_G1      = 6'b1_0_01_1_0;
  localparam logic [5:0] EXP_G2      = 6'b0_1_10_1_0;
  localparam logic [5:0] EXP_TURN    = 6'b0_0_00_1_0;
  localparam logic [5:0] EXP_TURN_TO = 6'b0_0_00_1_1;

  logic       clk = 1'b0;
  logic       rstA, req1A, req2A, ss1A, ss2A, busyA, timeoutA;
  logic [1:0] ownerA;
  logic       rstB, req1B, req2B, ss1B, ss2B, busyB, timeoutB;
  logic [1:0] ownerB;
  logic [5:0] obsA;
  logic [5:0] obsB;
`ifdef ARB_GRANT_CNT_EN
  logic [7:0] gcnt1A, gcnt2A;
  logic [1:0] gcnt1B, gcnt2B;
`endif

  int checks = 0;
  int errors = 0;

  assign obsA = {ss1A, ss2A, ownerA, busyA, timeoutA};
  assign obsB = {ss1B, ss2B, ownerB, busyB, timeoutB};

  always #5 clk = ~clk;

  miso_share_arbiter dut (
    .clk(clk), .rst(rstA), .req1(req1A), .req2(req2A),
    .ss1(ss1A), .ss2(ss2A), .owner(ownerA), .busy(busyA), .timeout(timeoutA)
`ifdef ARB_GRANT_CNT_EN
    , .gcnt1(gcnt1A), .gcnt2(gcnt2A)
`endif
  );

  miso_share_arbiter #(.HOLD_MAX(0), .TURN_CYCLES(2), .CNT_W(2)) dutB (
    .clk(clk), .rst(rstB), .req1(req1B), .req2(req2B),
    .ss1(ss1B), .ss2(ss2B), .owner(ownerB), .busy(busyB), .timeout(timeoutB)
`ifdef ARB_GRANT_CNT_EN
    , .gcnt1(gcnt1B), .gcnt2(gcnt2B)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetA();
    rstA = 1'b1; req1A = 1'b0; req2A = 1'b0;
    step(); step();
    rstA = 1'b0;
  endtask

  task automatic resetB();
    rstB = 1'b1; req1B = 1'b0; req2B = 1'b0;
    step(); step();
    rstB = 1'b0;
  endtask

  task automatic test_reset();
    rstA = 1'b1; req1A = 1'b1; req2A = 1'b1;
    rstB = 1'b1; req1B = 1'b0; req2B = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obsA !== EXP_IDLE) begin
        errors++;
        $display("[TB] FAIL reset_hold[%0d]: got %b expected %b", i, obsA, EXP_IDLE);
      end
    end
    rstA = 1'b0; rstB = 1'b0;
    step();
    checks++;
    if (obsA !== EXP_G1) begin
      errors++;
      $display("[TB] FAIL reset_first_grant: got %b expected %b", obsA, EXP_G1);
    end
  endtask

  task automatic test_release();
    logic [5:0] expSeq [4];
    expSeq = '{EXP_TURN, EXP_TURN, EXP_IDLE, EXP_IDLE};
    resetA();
    req1A = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obsA !== EXP_G1) begin
        errors++;
        $display("[TB] FAIL release_grant[%0d]: got %b expected %b", i, obsA, EXP_G1);
      end
    end
    req1A = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obsA !== expSeq[i]) begin
        errors++;
        $display("[TB] FAIL release_tail[%0d]: got %b expected %b", i, obsA, expSeq[i]);
      end
    end
  endtask

  task automatic test_alternation();
    logic [5:0] expV;
    int p;
    resetA();
    req1A = 1'b1; req2A = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step();
      p = c % 36;
      if (p < 16)       expV = EXP_G1;
      else if (p == 16) expV = EXP_TURN_TO;
      else if (p == 17) expV = EXP_TURN;
      else if (p < 34)  expV = EXP_G2;
      else if (p == 34) expV = EXP_TURN_TO;
      else              expV = EXP_TURN;
      checks++;
      if (obsA !== expV) begin
        errors++;
        $display("[TB] FAIL alternate[%0d]: got %b expected %b", c, obsA, expV);
      end
    end
    req1A = 1'b0; req2A = 1'b0;
  endtask

  task automatic test_round_robin_idle();
    resetA();
    req1A = 1'b1;
    step();
    req1A = 1'b0;
    step(); step(); step();
    req1A = 1'b1; req2A = 1'b1;
    step();
    checks++;
    if (obsA !== EXP_G2) begin
      errors++;
      $display("[TB] FAIL idle_tie_after_req1: got %b expected %b", obsA, EXP_G2);
    end
    req1A = 1'b0; req2A = 1'b0;
  endtask

  task automatic test_turn_sampling();
    resetA();
    req1A = 1'b1;
    step();
    req1A = 1'b0; req2A = 1'b1;
    step();
    req2A = 1'b0;
    step(); step();
    checks++;
    if (obsA !== EXP_IDLE) begin
      errors++;
      $display("[TB] FAIL turn_drop_ignored: got %b expected %b", obsA, EXP_IDLE);
    end
    req1A = 1'b1;
    step();
    req1A = 1'b0;
    step();
    req2A = 1'b1;
    step(); step();
    checks++;
    if (obsA !== EXP_G2) begin
      errors++;
      $display("[TB] FAIL turn_last_cycle_req: got %b expected %b", obsA, EXP_G2);
    end
    req2A = 1'b0;
  endtask

  task automatic test_unlimited_hold();
    logic [5:0] expSeq [3];
    expSeq = '{EXP_TURN, EXP_TURN, EXP_IDLE};
    resetB();
    req2B = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (obsB !== EXP_G2) begin
        errors++;
        $display("[TB] FAIL unlimited_grant[%0d]: got %b expected %b", i, obsB, EXP_G2);
      end
    end
    req2B = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obsB !== expSeq[i]) begin
        errors++;
        $display("[TB] FAIL unlimited_tail[%0d]: got %b expected %b", i, obsB, expSeq[i]);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    resetA();
    req2A = 1'b1;
    step(); step(); step();
    checks++;
    if (obsA !== EXP_G2) begin
      errors++;
      $display("[TB] FAIL midreset_pre: got %b expected %b", obsA, EXP_G2);
    end
    rstA = 1'b1; req1A = 1'b1;
    step();
    checks++;
    if (obsA !== EXP_IDLE) begin
      errors++;
      $display("[TB] FAIL midreset_drop: got %b expected %b", obsA, EXP_IDLE);
    end
    rstA = 1'b0;
    step();
    checks++;
    if (obsA !== EXP_G1) begin
      errors++;
      $display("[TB] FAIL midreset_regrant: got %b expected %b", obsA, EXP_G1);
    end
    resetA();
    req1A = 1'b1;
    step();
    rstA = 1'b1; req2A = 1'b1;
    step();
    rstA = 1'b0;
    step();
    checks++;
    if (obsA !== EXP_G1) begin
      errors++;
      $display("[TB] FAIL midreset_lastowner: got %b expected %b", obsA, EXP_G1);
    end
    req1A = 1'b0; req2A = 1'b0;
  endtask

`ifdef ARB_GRANT_CNT_EN
  task automatic test_grant_count();
    logic [1:0] expCnt;
    resetB();
    for (int k = 0; k < 5; k++) begin
      req1B = 1'b1;
      step();
      expCnt = (k >= 2) ? 2'd3 : 2'(k + 1);
      checks++;
      if (gcnt1B !== expCnt) begin
        errors++;
        $display("[TB] FAIL gcnt1[%0d]: got %0d expected %0d", k, gcnt1B, expCnt);
      end
      checks++;
      if (gcnt2B !== 2'd0) begin
        errors++;
        $display("[TB] FAIL gcnt2[%0d]: got %0d expected 0", k, gcnt2B);
      end
      req1B = 1'b0;
      step(); step(); step();
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstA = 1'b1; req1A = 1'b0; req2A = 1'b0;
    rstB = 1'b1; req1B = 1'b0; req2B = 1'b0;
    test_reset();
    test_release();
    test_alternation();
    test_round_robin_idle();
    test_turn_sampling();
    test_unlimited_hold();
    test_reset_mid_grant();
`ifdef ARB_GRANT_CNT_EN
    test_grant_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
